uart_apb_sequencer: RTL and testbench

// APB master that configures one CoreUARTapb and moves bytes between it and

---
 rtl/uart_apb_sequencer_if.sv | 42 ++++
 rtl/uart_apb_sequencer.sv | 156 +++++++++++++++
 tb/tb_uart_apb_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_apb_sequencer_if.sv
// Bus bundle between the UART APB sequencer and its surroundings: the APB
// master port toward CoreUARTapb plus the fabric-side byte streams and status.
interface uart_apb_sequencer_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [4:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       err_clr;
  logic [2:0] err_flags;
  logic       init_done;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY,
    input  tx_valid, tx_data,
    output tx_ready,
    output rx_valid, rx_data,
    input  rx_ready,
    input  err_clr,
    output err_flags, init_done
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY,
    output tx_valid, tx_data,
    input  tx_ready,
    input  rx_valid, rx_data,
    output rx_ready,
    output err_clr,
    input  err_flags, init_done
  );
endinterface

// File: rtl/uart_apb_sequencer.sv
// APB master that configures a CoreUARTapb (baud + control), then loops
// polling STATUS, draining RXDATA into an rx holding register and feeding
// TXDATA from a tx holding register. Fabric sees only valid/ready streams.
module uart_apb_sequencer #(
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter bit          BIT8       = 1'b1,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int          POLL_GAP   = 4
) (
  input logic                  PCLK,
  input logic                  PRESETN,
  uart_apb_sequencer_if.master bus
);

  typedef enum logic [2:0] {S_CFG1, S_CFG2, S_POLL, S_RD, S_WR, S_GAP} state_e;

  localparam logic [4:0] ADDR_TX   = 5'h00;
  localparam logic [4:0] ADDR_RX   = 5'h04;
  localparam logic [4:0] ADDR_CTL1 = 5'h08;
  localparam logic [4:0] ADDR_CTL2 = 5'h0C;
  localparam logic [4:0] ADDR_STAT = 5'h10;
  localparam logic [7:0] CTRL1_VAL = BAUD_VALUE[7:0];
  localparam logic [7:0] CTRL2_VAL = {BAUD_VALUE[12:8], PARITY_ODD, PARITY_EN, BIT8};
  localparam logic [7:0] GAP_LAST  = 8'(POLL_GAP - 1);

  state_e     state_q, state_d;
  logic       run_q, run_d;         // holds the bus idle in the first cycle out of reset
  logic       acc_q, acc_d;         // 0 = SETUP phase, 1 = ACCESS phase
  logic [7:0] gap_q, gap_d;
  logic       init_q, init_d;
  logic       tx_full_q, tx_full_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       rx_full_q, rx_full_d;
  logic [7:0] rx_buf_q, rx_buf_d;
  logic [2:0] err_q, err_d;

  logic       psel, penable, pwrite, done, tx_ready;
  logic [4:0] paddr;
  logic [7:0] pwdata;

  // Sequencer next-state, APB phase control, holding registers and sticky errors
  always_comb begin
    state_d   = state_q;
    run_d     = 1'b1;
    acc_d     = acc_q;
    gap_d     = gap_q;
    init_d    = init_q;
    tx_full_d = tx_full_q;
    tx_buf_d  = tx_buf_q;
    rx_full_d = rx_full_q;
    rx_buf_d  = rx_buf_q;
    err_d     = err_q;
    paddr     = 5'h00;
    pwrite    = 1'b0;
    pwdata    = 8'h00;

    psel     = run_q && (state_q != S_GAP);
    penable  = psel && acc_q;
    done     = penable && bus.PREADY;
    tx_ready = init_q && !tx_full_q;

    if (psel && !acc_q) acc_d = 1'b1;
    else if (done)      acc_d = 1'b0;

    if (psel) begin
      case (state_q)
        S_CFG1:  begin paddr = ADDR_CTL1; pwrite = 1'b1; pwdata = CTRL1_VAL; end
        S_CFG2:  begin paddr = ADDR_CTL2; pwrite = 1'b1; pwdata = CTRL2_VAL; end
        S_POLL:  paddr = ADDR_STAT;
        S_RD:    paddr = ADDR_RX;
        S_WR:    begin paddr = ADDR_TX; pwrite = 1'b1; pwdata = tx_buf_q; end
        default: paddr = 5'h00;
      endcase
    end

    if (bus.tx_valid && tx_ready) begin
      tx_full_d = 1'b1;
      tx_buf_d  = bus.tx_data;
    end
    if (rx_full_q && bus.rx_ready) rx_full_d = 1'b0;
    if (bus.err_clr) err_d = 3'b000;

    case (state_q)
      S_CFG1: if (done) state_d = S_CFG2;
      S_CFG2: if (done) begin
        state_d = S_POLL;
        init_d  = 1'b1;
      end
      S_POLL: if (done) begin
        // Error bits are ORed after the clear so a same-cycle set survives.
        err_d = err_d | {bus.PRDATA[4], bus.PRDATA[3], bus.PRDATA[2]};
        if (bus.PRDATA[1] && !rx_full_q)     state_d = S_RD;
        else if (bus.PRDATA[0] && tx_full_q) state_d = S_WR;
        else if (POLL_GAP == 0)              state_d = S_POLL;
        else begin
          state_d = S_GAP;
          gap_d   = 8'd0;
        end
      end
      S_RD: if (done) begin
        rx_buf_d  = bus.PRDATA;
        rx_full_d = 1'b1;
        state_d   = S_POLL;
      end
      S_WR: if (done) begin
        tx_full_d = 1'b0;
        state_d   = S_POLL;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_POLL;
        else                   gap_d   = gap_q + 8'd1;
      end
      default: state_d = S_CFG1;
    endcase
  end

  // State registers; reset aborts any transfer and empties both buffers
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q   <= S_CFG1;
      run_q     <= 1'b0;
      acc_q     <= 1'b0;
      gap_q     <= 8'd0;
      init_q    <= 1'b0;
      tx_full_q <= 1'b0;
      tx_buf_q  <= 8'h00;
      rx_full_q <= 1'b0;
      rx_buf_q  <= 8'h00;
      err_q     <= 3'b000;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      acc_q     <= acc_d;
      gap_q     <= gap_d;
      init_q    <= init_d;
      tx_full_q <= tx_full_d;
      tx_buf_q  <= tx_buf_d;
      rx_full_q <= rx_full_d;
      rx_buf_q  <= rx_buf_d;
      err_q     <= err_d;
    end
  end

  assign bus.PSEL      = psel;
  assign bus.PENABLE   = penable;
  assign bus.PWRITE    = pwrite;
  assign bus.PADDR     = paddr;
  assign bus.PWDATA    = pwdata;
  assign bus.tx_ready  = tx_ready;
  assign bus.rx_valid  = rx_full_q;
  assign bus.rx_data   = rx_buf_q;
  assign bus.err_flags = err_q;
  assign bus.init_done = init_q;

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Bench for uart_apb_sequencer: a behavioural APB slave that can park the
// sequencer inside a STATUS access, plus a transaction-level model of the
// holding registers and sticky errors that predicts each poll's outcome.
module tb_uart_apb_sequencer;
  localparam logic [12:0] BAUD = 13'h1A5;
  localparam int          GAP  = 4;

  typedef struct {
    logic [4:0] addr;
    logic       wr;
    logic [7:0] data;
    int         en;
  } xact_t;

  logic PCLK    = 1'b0;
  logic PRESETN = 1'b1;
  always #5 PCLK = ~PCLK;

  uart_apb_sequencer_if bus ();

  uart_apb_sequencer #(
    .BAUD_VALUE(BAUD), .BIT8(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .POLL_GAP(GAP)
  ) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .bus(bus)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  // slave state
  xact_t      log_q[$];
  int         cyc = 0;
  int         wait_cfg = 0;
  int         cnt = 0;
  int         en_cnt = 0;
  int         prot_err = 0;
  bit         hold = 1'b1;
  bit         release_one = 1'b0;
  bit         parked = 1'b0;
  logic [7:0] status_val = 8'h00;
  logic [7:0] rxdata_val = 8'h00;
  logic [4:0] s_addr;
  logic       s_wr;
  logic [7:0] s_data;
  int         st_setup_cyc = 0;
  int         st_done_cyc = 0;
  int         cfg2_done_cyc = -1;
  int         init_rise_cyc = -1;

  // model state
  bit         m_tx_full = 1'b0;
  logic [7:0] m_tx_data = 8'h00;
  bit         m_rx_full = 1'b0;
  logic [7:0] m_rx_data = 8'h00;
  logic [2:0] m_err = 3'b000;

  // APB slave: answers on the falling edge, logs every completed transfer
  initial begin
    bus.PREADY = 1'b0;
    bus.PRDATA = 8'h00;
    forever begin
      @(negedge PCLK);
      cyc++;
      if (bus.init_done === 1'b1 && init_rise_cyc < 0) init_rise_cyc = cyc;
      if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b0) begin
        cnt = wait_cfg;
        en_cnt = 0;
        bus.PREADY = 1'b0;
        s_addr = bus.PADDR;
        s_wr   = bus.PWRITE;
        s_data = bus.PWDATA;
        if (bus.PADDR == 5'h10) st_setup_cyc = cyc;
      end else if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
        en_cnt++;
        if (bus.PADDR !== s_addr || bus.PWRITE !== s_wr || bus.PWDATA !== s_data) prot_err++;
        if (bus.PADDR == 5'h10 && hold && !release_one) begin
          bus.PREADY = 1'b0;
          parked = 1'b1;
        end else if (cnt > 0) begin
          bus.PREADY = 1'b0;
          cnt--;
        end else begin
          bus.PREADY = 1'b1;
          case (bus.PADDR)
            5'h10:   bus.PRDATA = status_val;
            5'h04:   bus.PRDATA = rxdata_val;
            default: bus.PRDATA = 8'h00;
          endcase
          if (bus.PADDR == 5'h10) begin
            release_one = 1'b0;
            st_done_cyc = cyc;
          end
          if (bus.PADDR == 5'h0C) cfg2_done_cyc = cyc;
          log_q.push_back('{bus.PADDR, bus.PWRITE, bus.PWRITE ? bus.PWDATA : bus.PRDATA, en_cnt});
        end
      end else begin
        bus.PREADY = 1'b0;
      end
    end
  end

  task automatic wait_parked(input string tag);
    int n = 0;
    while (!parked && n < 300) begin
      @(negedge PCLK);
      #1;
      n++;
    end
    chk_cnt++;
    if (!parked) $display("FAIL %s_park_timeout: parked=%0d required 1", tag, parked);
    else pass_cnt++;
  endtask

  // One poll round: stream activity while parked, release one STATUS read,
  // then compare the transfers up to the next poll with the model's prediction.
  task automatic do_round(input string tag, input logic [7:0] s, input bit do_tx,
                          input logic [7:0] txb, input bit do_rx, input logic [7:0] rxb);
    int    exp_n;
    int    act;  // 0 none, 1 read RXDATA, 2 write TXDATA
    xact_t e;
    if (do_tx) begin
      chk_cnt++;
      if (bus.tx_ready !== !m_tx_full) $display("FAIL %s_tx_ready_pre: got %b required %b", tag, bus.tx_ready, !m_tx_full);
      else pass_cnt++;
    end
    if (do_rx) begin
      chk_cnt++;
      if (bus.rx_valid !== m_rx_full) $display("FAIL %s_rx_valid_pre: got %b required %b", tag, bus.rx_valid, m_rx_full);
      else pass_cnt++;
    end
    if (do_tx && !m_tx_full) begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = txb;
      m_tx_full = 1'b1;
      m_tx_data = txb;
    end
    if (do_rx && m_rx_full) begin
      bus.rx_ready = 1'b1;
      m_rx_full = 1'b0;
    end
    @(negedge PCLK);
    #1;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;

    act = 0;
    if (s[1] && !m_rx_full)     act = 1;
    else if (s[0] && m_tx_full) act = 2;
    exp_n = (act == 0) ? 1 : 2;

    status_val = s;
    rxdata_val = rxb;
    log_q.delete();
    parked = 1'b0;
    release_one = 1'b1;
    wait_parked(tag);

    m_err = m_err | s[4:2];
    chk_cnt++;
    if (log_q.size() != exp_n) begin
      $display("FAIL %s_xact_count: got %0d required %0d", tag, log_q.size(), exp_n);
    end else begin
      pass_cnt++;
      e = log_q[0];
      chk_cnt++;
      if ({e.addr, e.wr, e.data} !== {5'h10, 1'b0, s})
        $display("FAIL %s_status_read: got a=%h w=%b d=%h required a=10 w=0 d=%h", tag, e.addr, e.wr, e.data, s);
      else pass_cnt++;
      if (act == 1) begin
        e = log_q[1];
        chk_cnt++;
        if ({e.addr, e.wr} !== {5'h04, 1'b0}) $display("FAIL %s_rx_read: got a=%h w=%b required a=04 w=0", tag, e.addr, e.wr);
        else pass_cnt++;
        m_rx_full = 1'b1;
        m_rx_data = rxb;
      end else if (act == 2) begin
        e = log_q[1];
        chk_cnt++;
        if ({e.addr, e.wr, e.data} !== {5'h00, 1'b1, m_tx_data})
          $display("FAIL %s_tx_write: got a=%h w=%b d=%h required a=00 w=1 d=%h", tag, e.addr, e.wr, e.data, m_tx_data);
        else pass_cnt++;
        m_tx_full = 1'b0;
      end else begin
        chk_cnt++;
        if (st_setup_cyc - st_done_cyc !== GAP + 1)
          $display("FAIL %s_poll_gap: got %0d cycles required %0d", tag, st_setup_cyc - st_done_cyc, GAP + 1);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (bus.err_flags !== m_err) $display("FAIL %s_err_flags: got %b required %b", tag, bus.err_flags, m_err);
    else pass_cnt++;
    chk_cnt++;
    if (bus.tx_ready !== !m_tx_full) $display("FAIL %s_tx_ready: got %b required %b", tag, bus.tx_ready, !m_tx_full);
    else pass_cnt++;
    chk_cnt++;
    if (bus.rx_valid !== m_rx_full) $display("FAIL %s_rx_valid: got %b required %b", tag, bus.rx_valid, m_rx_full);
    else pass_cnt++;
    if (m_rx_full) begin
      chk_cnt++;
      if (bus.rx_data !== m_rx_data) $display("FAIL %s_rx_data: got %h required %h", tag, bus.rx_data, m_rx_data);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    xact_t e;
    #1 PRESETN = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA} !== 16'h0)
      $display("FAIL reset_apb: got sel=%b en=%b wr=%b a=%h d=%h required all 0", bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.tx_ready, bus.rx_valid, bus.rx_data, bus.err_flags, bus.init_done} !== 14'h0)
      $display("FAIL reset_stream: got txr=%b rxv=%b rxd=%h err=%b init=%b required all 0", bus.tx_ready, bus.rx_valid, bus.rx_data, bus.err_flags, bus.init_done);
    else pass_cnt++;
    repeat (2) @(negedge PCLK);
    PRESETN = 1'b1;
    wait_parked("reset");
    chk_cnt++;
    if (log_q.size() != 2) begin
      $display("FAIL cfg_count: got %0d required 2", log_q.size());
    end else begin
      pass_cnt++;
      e = log_q[0];
      chk_cnt++;
      if ({e.addr, e.wr, e.data} !== {5'h08, 1'b1, 8'hA5}) $display("FAIL cfg_ctrl1: got a=%h w=%b d=%h required a=08 w=1 d=a5", e.addr, e.wr, e.data);
      else pass_cnt++;
      e = log_q[1];
      chk_cnt++;
      if ({e.addr, e.wr, e.data} !== {5'h0C, 1'b1, 8'h0B}) $display("FAIL cfg_ctrl2: got a=%h w=%b d=%h required a=0c w=1 d=0b", e.addr, e.wr, e.data);
      else pass_cnt++;
    end
    chk_cnt++;
    if (init_rise_cyc !== cfg2_done_cyc + 1) $display("FAIL init_done_timing: got cycle %0d required %0d", init_rise_cyc, cfg2_done_cyc + 1);
    else pass_cnt++;
    chk_cnt++;
    if (bus.tx_ready !== 1'b1) $display("FAIL tx_ready_after_init: got %b required 1", bus.tx_ready);
    else pass_cnt++;
  endtask

  task automatic test_tx();
    do_round("tx", 8'h01, 1'b1, 8'h5A, 1'b0, 8'h00);
  endtask

  task automatic test_rx_priority();
    do_round("rxprio", 8'h03, 1'b1, 8'hA7, 1'b0, 8'hC3);
    chk_cnt++;
    if (bus.rx_data !== 8'hC3) $display("FAIL rxprio_data: got %h required c3", bus.rx_data);
    else pass_cnt++;
    do_round("rxprio_tx", 8'h01, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_gap();
    do_round("gap1", 8'h02, 1'b0, 8'h00, 1'b0, 8'h11);
    do_round("gap2", 8'h02, 1'b0, 8'h00, 1'b0, 8'h22);
  endtask

  task automatic test_pready_wait();
    wait_cfg = 3;
    do_round("wait", 8'h15, 1'b1, 8'h3C, 1'b0, 8'h00);
    chk_cnt++;
    if (log_q.size() == 2 && log_q[1].en != 4) $display("FAIL wait_penable_len: got %0d required 4", log_q[1].en);
    else if (log_q.size() != 2) $display("FAIL wait_penable_len: got no write required 4");
    else pass_cnt++;
    chk_cnt++;
    if (prot_err != 0) $display("FAIL apb_stability: got %0d violations required 0", prot_err);
    else pass_cnt++;
    chk_cnt++;
    if (bus.err_flags !== 3'b101) $display("FAIL wait_err_set: got %b required 101", bus.err_flags);
    else pass_cnt++;
    wait_cfg = 0;
    bus.err_clr = 1'b1;
    @(negedge PCLK);
    #1;
    bus.err_clr = 1'b0;
    m_err = 3'b000;
    chk_cnt++;
    if (bus.err_flags !== 3'b000) $display("FAIL err_clr: got %b required 000", bus.err_flags);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      wait_cfg = $urandom_range(0, 2);
      do_round("rand", 8'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 8'($urandom),
               1'($urandom_range(0, 1)), 8'($urandom));
    end
    wait_cfg = 0;
    chk_cnt++;
    if (prot_err != 0) $display("FAIL rand_apb_stability: got %0d violations required 0", prot_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int    n = 0;
    xact_t e;
    if (!m_tx_full) begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'h96;
      @(negedge PCLK);
      #1;
      bus.tx_valid = 1'b0;
    end
    wait_cfg = 20;
    status_val = 8'h01;
    parked = 1'b0;
    release_one = 1'b1;
    while (!(bus.PSEL === 1'b1 && bus.PENABLE === 1'b1 && bus.PWRITE === 1'b1 && bus.PADDR == 5'h00) && n < 200) begin
      @(negedge PCLK);
      #1;
      n++;
    end
    chk_cnt++;
    if (n >= 200) $display("FAIL midrst_wr_timeout: got no write access required one");
    else pass_cnt++;
    #2 PRESETN = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.PSEL, bus.PENABLE} !== 2'b00) $display("FAIL midrst_async: got sel=%b en=%b required 0 0", bus.PSEL, bus.PENABLE);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.tx_ready, bus.rx_valid, bus.init_done, bus.err_flags} !== 6'b0)
      $display("FAIL midrst_state: got txr=%b rxv=%b init=%b err=%b required all 0", bus.tx_ready, bus.rx_valid, bus.init_done, bus.err_flags);
    else pass_cnt++;
    m_tx_full = 1'b0;
    m_rx_full = 1'b0;
    m_err = 3'b000;
    wait_cfg = 0;
    release_one = 1'b0;
    parked = 1'b0;
    repeat (3) @(negedge PCLK);
    log_q.delete();
    PRESETN = 1'b1;
    wait_parked("midrst");
    chk_cnt++;
    if (log_q.size() < 1) begin
      $display("FAIL midrst_first: got no transfer required write 08<=a5");
    end else begin
      e = log_q[0];
      if ({e.addr, e.wr, e.data} !== {5'h08, 1'b1, 8'hA5}) $display("FAIL midrst_first: got a=%h w=%b d=%h required a=08 w=1 d=a5", e.addr, e.wr, e.data);
      else pass_cnt++;
    end
    do_round("post_rst", 8'h02, 1'b1, 8'h44, 1'b0, 8'h9E);
  endtask

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.rx_ready = 1'b0;
    bus.err_clr  = 1'b0;
    test_reset();
    test_tx();
    test_rx_priority();
    test_gap();
    test_pready_wait();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
